// File: rtl/add_resp_pkg.sv
// Shared types and defaults for the add_responder block.
// Optional feature macro: ADD_RESP_PARITY_EN (parity bit stored per result).
package add_resp_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } fifo_state_e;

    localparam int ADD_W     = 4;
    localparam int ADD_DEPTH = 4;
    localparam int ADD_CNT_W = 8;

    // Even parity over a zero-extended value; upper zero bits do not change it.
    function automatic logic par_of(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/add_responder_if.sv
// Operand / result handshake bundle for add_responder.
// Optional feature macro: ADD_RESP_PARITY_EN adds out_par.
interface add_responder_if
    import add_resp_pkg::*;
#(
    parameter int W     = ADD_W,
    parameter int CNT_W = ADD_CNT_W
) ();

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             out_valid;
    logic             out_ready;
    logic [W:0]       out_y;
    logic [CNT_W-1:0] txn_count;
    logic             busy;
`ifdef ADD_RESP_PARITY_EN
    logic             out_par;
`endif

    // Responder side: takes operands, returns results and status.
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_y, txn_count, busy
`ifdef ADD_RESP_PARITY_EN
        , output out_par
`endif
    );

    // Driver/consumer side.
    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_y, txn_count, busy
`ifdef ADD_RESP_PARITY_EN
        , input out_par
`endif
    );

endinterface

// File: rtl/add_resp_fifo.sv
// Synchronous result FIFO with an explicit EMPTY/PARTIAL/FULL state machine.
// Pointers wrap naturally because DEPTH is a power of two (minimum 2).
module add_resp_fifo
    import add_resp_pkg::*;
#(
    parameter int DW    = ADD_W + 1,
    parameter int DEPTH = ADD_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          empty,
    output logic          full
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [OW-1:0] occ_r;
    fifo_state_e   state_r;

    // Storage, pointers, occupancy and state advance together; a push in FULL
    // and a pop in EMPTY are ignored by construction of the state cases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= EMPTY;
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            occ_r    <= {OW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
        end else begin
            case (state_r)
                EMPTY: begin
                    if (push) begin
                        mem_r[wr_ptr_r] <= wdata;
                        wr_ptr_r        <= wr_ptr_r + AW'(1);
                        occ_r           <= OW'(1);
                        state_r         <= PARTIAL;
                    end
                end
                PARTIAL: begin
                    if (push) begin
                        mem_r[wr_ptr_r] <= wdata;
                        wr_ptr_r        <= wr_ptr_r + AW'(1);
                    end
                    if (pop) begin
                        rd_ptr_r <= rd_ptr_r + AW'(1);
                    end
                    if (push && !pop) begin
                        occ_r <= occ_r + OW'(1);
                        if (occ_r == OW'(DEPTH - 1)) begin
                            state_r <= FULL;
                        end
                    end else if (!push && pop) begin
                        occ_r <= occ_r - OW'(1);
                        if (occ_r == OW'(1)) begin
                            state_r <= EMPTY;
                        end
                    end
                end
                FULL: begin
                    if (pop) begin
                        rd_ptr_r <= rd_ptr_r + AW'(1);
                        occ_r    <= occ_r - OW'(1);
                        state_r  <= PARTIAL;
                    end
                end
                default: begin
                    state_r <= EMPTY;
                end
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign empty = (state_r == EMPTY);
    assign full  = (state_r == FULL);

endmodule

// File: rtl/add_responder.sv
// Responder end of the operand adder interface: adds a+b with carry kept,
// buffers results in add_resp_fifo and counts accepted operand pairs.
// Optional feature macro: ADD_RESP_PARITY_EN stores and presents out_par.
module add_responder
    import add_resp_pkg::*;
#(
    parameter int W     = ADD_W,
    parameter int DEPTH = ADD_DEPTH,
    parameter int CNT_W = ADD_CNT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    add_responder_if.slave  bus
);

`ifdef ADD_RESP_PARITY_EN
    localparam int DW = W + 2;
`else
    localparam int DW = W + 1;
`endif

    logic [W:0]       sum_s;
    logic [DW-1:0]    wdata_s;
    logic [DW-1:0]    rdata_s;
    logic             empty_s;
    logic             full_s;
    logic             push_s;
    logic             pop_s;
    logic [CNT_W-1:0] txn_count_r;

    // Zero-extended add: W+1 bits can never overflow.
    assign sum_s = {1'b0, bus.in_a} + {1'b0, bus.in_b};

`ifdef ADD_RESP_PARITY_EN
    assign wdata_s = {par_of(32'(sum_s)), sum_s};
`else
    assign wdata_s = sum_s;
`endif

    // in_ready comes from FSM state only, so a pop while FULL cannot admit a push.
    assign push_s = bus.in_valid && !full_s;
    assign pop_s  = !empty_s && bus.out_ready;

    add_resp_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (wdata_s),
        .rdata (rdata_s),
        .empty (empty_s),
        .full  (full_s)
    );

    // Accepted-transfer counter, wraps modulo 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count_r <= {CNT_W{1'b0}};
        end else if (push_s) begin
            txn_count_r <= txn_count_r + CNT_W'(1);
        end else begin
            txn_count_r <= txn_count_r;
        end
    end

    assign bus.in_ready  = !full_s;
    assign bus.out_valid = !empty_s;
    assign bus.busy      = !empty_s;
    assign bus.out_y     = rdata_s[W:0];
    assign bus.txn_count = txn_count_r;
`ifdef ADD_RESP_PARITY_EN
    assign bus.out_par   = rdata_s[W+1];
`endif

endmodule

// File: tb/tb_add_responder.sv
// Directed self-checking bench for add_responder (W=4, DEPTH=4, CNT_W=8).
// Parity checks are compiled in when ADD_RESP_PARITY_EN is defined.
module tb_add_responder;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    add_responder_if #(.W(4), .CNT_W(8)) bus ();

    add_responder #(.W(4), .DEPTH(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_a      = 4'd0;
        bus.in_b      = 4'd0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_a      = 4'd0;
        bus.in_b      = 4'd0;
        step();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_y !== 5'd0) begin errors++; $display("FAIL reset_out_y: got %0d expected 0", bus.out_y); end
        checks++; if (bus.txn_count !== 8'd0) begin errors++; $display("FAIL reset_txn: got %0d expected 0", bus.txn_count); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        rst_n = 1'b1;
        // X operands without in_valid must be ignored
        bus.in_a = 4'bxxxx;
        bus.in_b = 4'bxxxx;
        step();
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL x_idle_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.txn_count !== 8'd0) begin errors++; $display("FAIL x_idle_txn: got %0d expected 0", bus.txn_count); end
        checks++; if (bus.out_y !== 5'd0) begin errors++; $display("FAIL x_idle_y: got %b expected 00000", bus.out_y); end
        bus.in_a = 4'd0;
        bus.in_b = 4'd0;
    endtask

    task automatic test_single();
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = 4'd9;
        bus.in_b      = 4'd8;
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", bus.out_valid); end
        checks++; if (bus.out_y !== 5'b10001) begin errors++; $display("FAIL single_y: got %0d expected 17", bus.out_y); end
        checks++; if (bus.txn_count !== 8'd1) begin errors++; $display("FAIL single_txn: got %0d expected 1", bus.txn_count); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", bus.busy); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got %b expected 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", bus.busy); end
    endtask

    task automatic test_fill_drain();
        logic [3:0] va [4];
        logic [3:0] vb [4];
        logic [4:0] ey [3];
        va[0] = 4'd1;  vb[0] = 4'd2;
        va[1] = 4'd3;  vb[1] = 4'd4;
        va[2] = 4'd15; vb[2] = 4'd15;
        va[3] = 4'd0;  vb[3] = 4'd0;
        ey[0] = 5'd7;  ey[1] = 5'd30; ey[2] = 5'd0;
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = va[i];
            bus.in_b     = vb[i];
            step();
            checks++;
            if (bus.in_ready !== ((i < 3) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL fill_in_ready[%0d]: got %b expected %b", i, bus.in_ready, (i < 3) ? 1'b1 : 1'b0);
            end
        end
        // 5th offer while FULL and not draining
        bus.in_a = 4'd1;
        bus.in_b = 4'd1;
        step();
        checks++; if (bus.txn_count !== 8'd4) begin errors++; $display("FAIL full_ignore_txn: got %0d expected 4", bus.txn_count); end
        checks++; if (bus.out_y !== 5'd3) begin errors++; $display("FAIL full_hold_y: got %0d expected 3", bus.out_y); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b expected 0", bus.in_ready); end
        // pop while FULL with in_valid still high: no push in the same cycle
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.txn_count !== 8'd4) begin errors++; $display("FAIL full_pop_txn: got %0d expected 4", bus.txn_count); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready: got %b expected 1", bus.in_ready); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_y !== ey[i]) begin
                errors++; $display("FAIL drain[%0d]: got valid=%b y=%0d expected valid=1 y=%0d", i, bus.out_valid, bus.out_y, ey[i]);
            end
            step();
        end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_push_pop();
        do_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a = 4'd1; bus.in_b = 4'd1;
        step();
        bus.in_a = 4'd2; bus.in_b = 4'd2;
        step();
        // two entries buffered (2, 4); push 11 and pop 2 together
        bus.in_a = 4'd5; bus.in_b = 4'd6;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++; if (bus.out_y !== 5'd4) begin errors++; $display("FAIL pp_head: got %0d expected 4", bus.out_y); end
        checks++; if (bus.txn_count !== 8'd3) begin errors++; $display("FAIL pp_txn: got %0d expected 3", bus.txn_count); end
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_y !== 5'd11) begin errors++; $display("FAIL pp_second: got valid=%b y=%0d expected valid=1 y=11", bus.out_valid, bus.out_y); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL pp_empty: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] va [12];
        logic [3:0] vb [12];
        logic [4:0] ey [12];
        va[0]=4'd0;  vb[0]=4'd0;   ey[0]=5'd0;
        va[1]=4'd1;  vb[1]=4'd0;   ey[1]=5'd1;
        va[2]=4'd15; vb[2]=4'd1;   ey[2]=5'd16;
        va[3]=4'd8;  vb[3]=4'd8;   ey[3]=5'd16;
        va[4]=4'd7;  vb[4]=4'd9;   ey[4]=5'd16;
        va[5]=4'd15; vb[5]=4'd14;  ey[5]=5'd29;
        va[6]=4'd2;  vb[6]=4'd13;  ey[6]=5'd15;
        va[7]=4'd10; vb[7]=4'd5;   ey[7]=5'd15;
        va[8]=4'd12; vb[8]=4'd12;  ey[8]=5'd24;
        va[9]=4'd6;  vb[9]=4'd3;   ey[9]=5'd9;
        va[10]=4'd11; vb[10]=4'd4; ey[10]=5'd15;
        va[11]=4'd9; vb[11]=4'd15; ey[11]=5'd24;
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = va[i];
            bus.in_b     = vb[i];
            step();
            checks++;
            if (bus.out_y !== ey[i] || bus.out_valid !== 1'b1) begin
                errors++; $display("FAIL b2b[%0d]: got valid=%b y=%0d expected valid=1 y=%0d", i, bus.out_valid, bus.out_y, ey[i]);
            end
        end
        bus.in_valid = 1'b0;
        checks++; if (bus.txn_count !== 8'd12) begin errors++; $display("FAIL b2b_txn: got %0d expected 12", bus.txn_count); end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_b      = 4'd0;
        for (int i = 0; i < 256; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 4'(i);
            step();
            if (i == 254) begin
                checks++; if (bus.txn_count !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d expected 255", bus.txn_count); end
            end
        end
        bus.in_valid = 1'b0;
        checks++; if (bus.txn_count !== 8'd0) begin errors++; $display("FAIL wrap_zero: got %0d expected 0", bus.txn_count); end
        checks++; if (bus.out_y !== 5'd15) begin errors++; $display("FAIL wrap_last_y: got %0d expected 15", bus.out_y); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_a = 4'(i + 1);
            bus.in_b = 4'd1;
            step();
        end
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL async_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.txn_count !== 8'd0) begin errors++; $display("FAIL async_txn: got %0d expected 0", bus.txn_count); end
        step();
        rst_n = 1'b1;
        step();
        bus.in_valid = 1'b1;
        bus.in_a     = 4'd3;
        bus.in_b     = 4'd3;
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_y !== 5'd6 || bus.txn_count !== 8'd1) begin errors++; $display("FAIL post_reset: got y=%0d txn=%0d expected y=6 txn=1", bus.out_y, bus.txn_count); end
    endtask

`ifdef ADD_RESP_PARITY_EN
    task automatic test_parity();
        do_reset();
        checks++; if (bus.out_par !== 1'b0) begin errors++; $display("FAIL par_reset: got %b expected 0", bus.out_par); end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a = 4'd7; bus.in_b = 4'd0;
        step();
        checks++; if (bus.out_y !== 5'd7 || bus.out_par !== 1'b1) begin errors++; $display("FAIL par_7: got y=%0d par=%b expected y=7 par=1", bus.out_y, bus.out_par); end
        bus.in_a = 4'd3; bus.in_b = 4'd0;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_y !== 5'd3 || bus.out_par !== 1'b0) begin errors++; $display("FAIL par_3: got y=%0d par=%b expected y=3 par=0", bus.out_y, bus.out_par); end
    endtask
`endif

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_a      = 4'd0;
        bus.in_b      = 4'd0;
        test_reset();
        test_single();
        test_fill_drain();
        test_push_pop();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
`ifdef ADD_RESP_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
